pipe_stage_reg: RTL and testbench

- Parametrised, handshaked successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque control bundle and data bundle between stages with valid/ready flow control, an optional 2-entry skid buffer for timing isolation, and flush (CLR) that inserts NOP bubbles.
- One instance per stage boundary; the Hazard_Unit drives CLR and observes stalls through out_ready and in_ready.

---
 rtl/pipe_stage_reg.sv | 177 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked inter-stage pipeline register.
// Carries an opaque control bundle and data bundle from one stage to the next
// with valid/ready flow control. SKID=1 adds an overflow entry so that in_ready
// is registered; SKID=0 keeps a single entry with in_ready derived from out_ready.
// CLR flushes the stage to a bubble (control zeroed). RST does the same and
// also clears the optional counters.
// Optional feature macro: PIPE_STAGE_PERF_EN (stall/bubble counters, CNT_W).
module pipe_stage_reg #(
  parameter int CTRL_W = 20,
  parameter int DATA_W = 175,
  parameter int SKID   = 1
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                accept_s;
  logic                pop_s;

  assign accept_s  = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  // A bubble always presents an all-zero control bundle downstream.
  assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
  // Data is left as-is when empty; only RST/CLR zero it.
  assign out_data  = main_data_q;

  // Next-state and datapath selection; flush overrides any handshake.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (CLR) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = {CTRL_W{1'b0}};
      main_data_d = {DATA_W{1'b0}};
      skid_ctrl_d = {CTRL_W{1'b0}};
      skid_data_d = {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d     = ST_FULL;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept_s && pop_s) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
          end else if (accept_s && (SKID != 0)) begin
            state_d     = ST_SKID;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_SKID: begin
          if (pop_s) begin
            state_d     = ST_FULL;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = {CTRL_W{1'b0}};
          main_data_d = {DATA_W{1'b0}};
        end
      endcase
    end
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= {CTRL_W{1'b0}};
      main_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      // Registered ready: deasserted only while both entries are held.
      always_ff @(posedge CLK) begin
        if (RST) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != ST_SKID);
        end
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = (state_q == ST_EMPTY) | out_ready;
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Saturating stall/bubble counters; only RST clears them, CLR does not.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q  <= {CNT_W{1'b0}};
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (!out_valid && out_ready && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_q <= bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        bubble_cnt_q <= bubble_cnt_q;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: instance a (SKID=1, default widths)
// and instance b (SKID=0, narrow data). Accepted beats are queued; monitors
// pop and compare on every downstream handshake.
module tb_pipe_stage_reg;

  localparam int CW  = 20;
  localparam int DWA = 175;
  localparam int DWB = 32;

  logic clk = 1'b0;
  logic rst, clr;

  logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0]   a_in_ctrl, a_out_ctrl;
  logic [DWA-1:0]  a_in_data, a_out_data;
  logic [1:0]      a_occ;

  logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0]   b_in_ctrl, b_out_ctrl;
  logic [DWB-1:0]  b_in_data, b_out_data;
  logic [1:0]      b_occ;

`ifdef PIPE_STAGE_PERF_EN
  logic [3:0] a_stall, a_bubble, b_stall, b_bubble;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [CW+DWA-1:0] sb_a[$];
  logic [CW+DWB-1:0] sb_b[$];
  logic [CW+DWA-1:0] exp_a;
  logic [CW+DWB-1:0] exp_b;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DWA), .SKID(1)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(4)
`endif
  ) u_a (
    .CLK(clk), .RST(rst), .CLR(clr),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(a_stall), .bubble_cnt(a_bubble)
`endif
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DWB), .SKID(0)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(4)
`endif
  ) u_b (
    .CLK(clk), .RST(rst), .CLR(clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(b_stall), .bubble_cnt(b_bubble)
`endif
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard push: every accepted upstream beat is expected downstream.
  always @(negedge clk) begin
    if (!rst && !clr) begin
      if (a_in_valid && a_in_ready) sb_a.push_back({a_in_ctrl, a_in_data});
      if (b_in_valid && b_in_ready) sb_b.push_back({b_in_ctrl, b_in_data});
    end
  end

  // Monitor: compare every downstream handshake against the queue head.
  always @(negedge clk) begin
    if (!rst && !clr) begin
      if (a_out_valid && a_out_ready) begin
        if (sb_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL a_unexpected: got ctrl %0h expected no beat", a_out_ctrl);
        end else begin
          exp_a = sb_a.pop_front();
          chk("a_ctrl", 256'(a_out_ctrl), 256'(exp_a[CW+DWA-1:DWA]));
          chk("a_data", 256'(a_out_data), 256'(exp_a[DWA-1:0]));
        end
      end
      if (b_out_valid && b_out_ready) begin
        if (sb_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected: got ctrl %0h expected no beat", b_out_ctrl);
        end else begin
          exp_b = sb_b.pop_front();
          chk("b_ctrl", 256'(b_out_ctrl), 256'(exp_b[CW+DWB-1:DWB]));
          chk("b_data", 256'(b_out_data), 256'(exp_b[DWB-1:0]));
        end
      end
      if (!a_out_valid) chk("a_ctrl_gate", 256'(a_out_ctrl), 256'd0);
      if (!b_out_valid) chk("b_ctrl_gate", 256'(b_out_ctrl), 256'd0);
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_ctrl = '0; a_in_data = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_ctrl = '0; b_in_data = '0;
    step(); step();
    chk("rst_out_valid", 256'(a_out_valid), 256'd0);
    chk("rst_out_ctrl",  256'(a_out_ctrl),  256'd0);
    chk("rst_out_data",  256'(a_out_data),  256'd0);
    chk("rst_occ",       256'(a_occ),       256'd0);
    chk("rst_in_ready",  256'(a_in_ready),  256'd1);
    rst = 1'b0;

    // Stream five beats at full rate, one-cycle latency.
    a_out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      a_in_valid = 1'b1;
      a_in_ctrl  = CW'(i);
      a_in_data  = DWA'(i * 32'h111);
      step();
      chk("stream_ctrl", 256'(a_out_ctrl), 256'(i));
      chk("stream_rdy",  256'(a_in_ready), 256'd1);
    end
    a_in_valid = 1'b0;
    step();
    chk("stream_drain_occ", 256'(a_occ), 256'd0);
    chk("hold_data", 256'(a_out_data), 256'h555);

    // Fill both entries with downstream stalled.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 20'h0000A; a_in_data = DWA'(32'hAAAA);
    step();
    a_in_ctrl = 20'h0000B; a_in_data = DWA'(32'hBBBB);
    step();
    a_in_valid = 1'b0;
    chk("skid_occ",   256'(a_occ),      256'd2);
    chk("skid_rdy",   256'(a_in_ready), 256'd0);
    chk("skid_ctrlA", 256'(a_out_ctrl), 256'h0000A);
    // A held beat while not ready must not change anything.
    a_in_valid = 1'b1; a_in_ctrl = 20'h0000C; a_in_data = DWA'(32'hCCCC);
    step();
    a_in_valid = 1'b0;
    chk("skid_hold_occ", 256'(a_occ), 256'd2);
    a_out_ready = 1'b1;
    step();
    chk("drain1_occ",  256'(a_occ),      256'd1);
    chk("drain1_ctrl", 256'(a_out_ctrl), 256'h0000B);
    chk("drain1_rdy",  256'(a_in_ready), 256'd1);
    step();
    chk("drain2_occ",  256'(a_occ),       256'd0);
    chk("drain2_vld",  256'(a_out_valid), 256'd0);

    // Flush while both entries are held; the concurrent beat is dropped.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 20'h00021; a_in_data = DWA'(32'h2121);
    step();
    a_in_ctrl = 20'h00022; a_in_data = DWA'(32'h2222);
    step();
    chk("fl_pre_occ", 256'(a_occ), 256'd2);
    clr = 1'b1; a_in_ctrl = 20'h00023; a_in_data = DWA'(32'h2323);
    step();
    clr = 1'b0; a_in_valid = 1'b0;
    sb_a.delete();
    chk("fl_vld",  256'(a_out_valid), 256'd0);
    chk("fl_ctrl", 256'(a_out_ctrl),  256'd0);
    chk("fl_data", 256'(a_out_data),  256'd0);
    chk("fl_occ",  256'(a_occ),       256'd0);
    chk("fl_rdy",  256'(a_in_ready),  256'd1);
    a_out_ready = 1'b1;
    step(); step(); step();
    chk("fl_after_vld", 256'(a_out_valid), 256'd0);

    // SKID=0 instance: combinational ready from out_ready.
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_ctrl = 20'h00011; b_in_data = 32'h1111_0011;
    step();
    b_in_valid = 1'b0;
    chk("b_full_occ", 256'(b_occ), 256'd1);
    chk("b_rdy_low",  256'(b_in_ready), 256'd0);
    b_out_ready = 1'b1;
    #1;
    chk("b_rdy_comb", 256'(b_in_ready), 256'd1);
    b_in_valid = 1'b1; b_in_ctrl = 20'h00012; b_in_data = 32'h1111_0012;
    step();
    chk("b_ap_occ",  256'(b_occ),      256'd1);
    chk("b_ap_ctrl", 256'(b_out_ctrl), 256'h00012);
    b_in_ctrl = 20'h00013; b_in_data = 32'h1111_0013;
    step();
    chk("b_ap2_ctrl", 256'(b_out_ctrl), 256'h00013);
    b_in_valid = 1'b0;
    step();
    chk("b_drain_occ", 256'(b_occ), 256'd0);

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter saturation, CLR immunity, RST clear.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 20'h00031; a_in_data = DWA'(32'h3131);
    step();
    a_in_valid = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("perf_sat", 256'(a_stall), 256'd15);
    clr = 1'b1;
    step();
    clr = 1'b0;
    sb_a.delete();
    chk("perf_clr", 256'(a_stall), 256'd15);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("perf_rst", 256'(a_stall), 256'd0);
`endif

    step();
    chk("a_sb_empty", 256'(sb_a.size()), 256'd0);
    chk("b_sb_empty", 256'(sb_b.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
